// File: rtl/im_port_arbiter.sv
// rtl/im_port_arbiter.sv - single-port instruction memory arbiter for CPU fetch and program loader
module im_port_arbiter #(
   parameter int unsigned ADDR_W     = 14,
   parameter logic [31:0] BASE       = 32'h0000_3000,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   input  logic [31:0]       f_addr,
   output logic              f_gnt,
   output logic              f_valid,
   output logic [31:0]       f_instr,
   output logic              f_err,
   input  logic              l_req,
   input  logic [31:0]       l_addr,
   input  logic [31:0]       l_wdata,
   input  logic              l_last,
   output logic              l_gnt,
   output logic              l_err,
   output logic              l_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned     SC_W   = $clog2(STARVE_MAX + 1);
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);
   localparam logic [32:0]     WIN    = 33'd1 << ADDR_W;

   typedef enum logic {IDLE, BURST} state_t;

   state_t          state_q;
   logic [SC_W-1:0] sc_q;
   logic            f_valid_q;
   logic            f_err_q;
   logic            l_err_q;
   logic            l_done_q;
   logic [31:0]     instr_q;

   logic [31:0]     acc_addr;
   logic [31:0]     acc_off;
   logic            acc_legal;
   logic            any_gnt;

   // Grant selection: loader has priority, except a starved fetch is forced in during a burst
   always_comb begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
      if (!rst) begin
         if ((state_q == BURST) && l_req && f_req && (sc_q == SC_MAX)) begin
            f_gnt = 1'b1;
         end else if (l_req) begin
            l_gnt = 1'b1;
         end else if (f_req) begin
            f_gnt = 1'b1;
         end
      end
   end

   // The unsigned subtract makes addresses below BASE huge, so one compare rejects both sides
   assign acc_addr  = f_gnt ? f_addr : l_addr;
   assign acc_off   = acc_addr - BASE;
   assign acc_legal = (acc_addr[1:0] == 2'b00) && ({1'b0, acc_off} < WIN);
   assign any_gnt   = f_gnt | l_gnt;

   assign mem_en    = any_gnt & acc_legal;
   assign mem_we    = l_gnt & acc_legal;
   assign mem_addr  = mem_en ? acc_off[ADDR_W-1:2] : '0;
   assign mem_wdata = mem_we ? l_wdata : '0;

   // Read data arrives the cycle after the grant; otherwise show the last delivered word
   assign f_instr = f_valid_q ? (f_err_q ? 32'h0 : mem_rdata) : instr_q;
   assign f_valid = f_valid_q;
   assign f_err   = f_err_q;
   assign l_err   = l_err_q;
   assign l_done  = l_done_q;

   // Burst ownership and count of loader beats taken while a fetch waits
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sc_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               sc_q <= '0;
               if (l_gnt && !l_last) begin
                  state_q <= BURST;
                  if (f_req) begin
                     sc_q <= SC_W'(1);
                  end
               end
            end
            BURST: begin
               if (l_gnt && l_last) begin
                  state_q <= IDLE;
                  sc_q    <= '0;
               end else if (!f_req || f_gnt) begin
                  sc_q <= '0;
               end else if (l_gnt) begin
                  sc_q <= sc_q + SC_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               sc_q    <= '0;
            end
         endcase
      end
   end

   // Response flags for the access granted in the previous cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         f_valid_q <= 1'b0;
         f_err_q   <= 1'b0;
         l_err_q   <= 1'b0;
         l_done_q  <= 1'b0;
         instr_q   <= 32'h0;
      end else begin
         f_valid_q <= f_gnt;
         f_err_q   <= f_gnt & ~acc_legal;
         l_err_q   <= l_gnt & ~acc_legal;
         l_done_q  <= l_gnt & l_last;
         instr_q   <= f_instr;
      end
   end

endmodule

// File: tb/tb_im_port_arbiter.sv
// tb/tb_im_port_arbiter.sv - scoreboard bench for im_port_arbiter
module tb_im_port_arbiter;

   localparam int STARVE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        f_req = 1'b0;
   logic [31:0] f_addr = 32'h0;
   logic        f_gnt;
   logic        f_valid;
   logic [31:0] f_instr;
   logic        f_err;
   logic        l_req = 1'b0;
   logic [31:0] l_addr = 32'h0;
   logic [31:0] l_wdata = 32'h0;
   logic        l_last = 1'b0;
   logic        l_gnt;
   logic        l_err;
   logic        l_done;
   logic        mem_en;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;

   logic        mem_load = 1'b1;
   logic [31:0] mem    [4096];
   logic [31:0] refmem [4096];

   int          checks = 0;
   int          errors = 0;
   int          beats_done = 0;

   logic [32:0] fq [$];
   logic [31:0] last_instr = 32'h0;
   logic        exp_fv = 1'b0;
   logic        exp_lerr = 1'b0;
   logic        exp_ldone = 1'b0;
   logic        m_burst = 1'b0;
   int          m_beats = 0;

   im_port_arbiter dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid),
      .f_instr(f_instr), .f_err(f_err),
      .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_last(l_last),
      .l_gnt(l_gnt), .l_err(l_err), .l_done(l_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      if (i == 0) return 32'h08000c08;
      return 32'ha500_0000 ^ (32'(i) * 32'h0101_0101);
   endfunction

   function automatic logic addr_ok(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a < 32'h0000_7000);
   endfunction

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(19, 0);
      case (r)
         0: return 32'h0000_2ffc;
         1: return 32'h0000_7000;
         2: return 32'h0000_3000 + 32'($urandom_range(3, 1));
         3: return 32'h0000_6ff0;
         4: return $urandom;
         default: return 32'h0000_3000 + 32'($urandom_range(63, 0)) * 32'd4;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Synchronous-read memory model
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   // Monitor and reference model, evaluated mid-cycle
   always @(negedge clk) begin : mon
      logic [32:0] e;
      logic [31:0] a;
      logic        lg, ef, el;
      int          idx;
      if (mem_load) begin
         for (int i = 0; i < 4096; i++) refmem[i] = init_word(i);
      end
      chk("f_valid", 32'(f_valid), 32'(exp_fv));
      chk("l_err", 32'(l_err), 32'(exp_lerr));
      chk("l_done", 32'(l_done), 32'(exp_ldone));
      if (f_valid) begin
         if (fq.size() == 0) begin
            checks++; errors++;
            $display("FAIL f_unexpected: f_valid=1 with no outstanding fetch at %0t", $time);
         end else begin
            e = fq.pop_front();
            chk("f_instr", f_instr, e[31:0]);
            chk("f_err", 32'(f_err), 32'(e[32]));
            last_instr = e[31:0];
         end
      end else begin
         chk("f_instr_hold", f_instr, last_instr);
      end
      if (rst) last_instr = 32'h0;

      ef = 1'b0; el = 1'b0;
      if (!rst) begin
         if (f_req && (!l_req || (m_burst && m_beats == STARVE))) ef = 1'b1;
         else if (l_req) el = 1'b1;
      end
      chk("f_gnt", 32'(f_gnt), 32'(ef));
      chk("l_gnt", 32'(l_gnt), 32'(el));

      a   = ef ? f_addr : l_addr;
      lg  = (ef || el) && addr_ok(a);
      idx = lg ? int'((a - 32'h0000_3000) >> 2) : 0;
      chk("mem_en", 32'(mem_en), 32'(lg));
      chk("mem_we", 32'(mem_we), 32'(el && lg));
      chk("mem_addr", 32'(mem_addr), 32'(idx));
      chk("mem_wdata", mem_wdata, (el && lg) ? l_wdata : 32'h0);

      if (ef) fq.push_back({~lg, lg ? refmem[idx] : 32'h0});
      if (el && lg) refmem[idx] = l_wdata;
      exp_fv    = ef;
      exp_lerr  = el && !lg;
      exp_ldone = el && l_last;

      if (rst) begin
         m_burst = 1'b0;
         m_beats = 0;
      end else if (el) begin
         if (l_last) begin
            m_burst = 1'b0;
            m_beats = 0;
         end else begin
            m_burst = 1'b1;
            m_beats = f_req ? m_beats + 1 : 0;
         end
      end else if (ef || !f_req) begin
         m_beats = 0;
      end
   end

   task automatic fetch(input logic [31:0] a);
      int n;
      n = 0;
      f_req  = 1'b1;
      f_addr = a;
      do begin
         @(negedge clk);
         n++;
      end while (!f_gnt && n < 200);
      if (!f_gnt) begin
         checks++; errors++;
         $display("FAIL fetch_timeout: no f_gnt for %h expected within 200 cycles", a);
      end
      @(posedge clk); #1;
      f_req = 1'b0;
   endtask

   task automatic burst(input logic [31:0] a0, input int n, input int gapmax);
      int g, w;
      beats_done = 0;
      for (int i = 0; i < n; i++) begin
         g = (gapmax > 0) ? $urandom_range(gapmax, 0) : 0;
         l_req = 1'b0;
         repeat (g) begin @(posedge clk); #1; end
         l_req   = 1'b1;
         l_addr  = a0 + 32'(i) * 32'd4;
         l_wdata = $urandom;
         l_last  = (i == n - 1);
         w = 0;
         do begin
            @(negedge clk);
            w++;
         end while (!l_gnt && w < 200);
         if (l_gnt) beats_done++;
         else begin
            checks++; errors++;
            $display("FAIL burst_timeout: no l_gnt for %h expected within 200 cycles", l_addr);
         end
         @(posedge clk); #1;
      end
      l_req  = 1'b0;
      l_last = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      time t0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      mem_load = 1'b0;
      chk("rst_f_valid", 32'(f_valid), 32'd0);
      chk("rst_f_instr", f_instr, 32'h0);
      chk("rst_l_done", 32'(l_done), 32'd0);

      fetch(32'h0000_3000);
      chk("t1_valid", 32'(f_valid), 32'd1);
      chk("t1_instr", f_instr, 32'h08000c08);

      fork
         burst(32'h0000_3000, 3, 0);
         begin
            fetch(32'h0000_3000);
            chk("t2_fetch_after_burst", 32'(beats_done), 32'd3);
         end
      join

      fork
         burst(32'h0000_3100, 10, 0);
         begin
            fetch(32'h0000_3100);
            chk("t3_starve_beats", 32'(beats_done), 32'(STARVE));
         end
      join

      fetch(32'h0000_3002);
      chk("t4_misaligned_err", 32'(f_err), 32'd1);
      chk("t4_misaligned_instr", f_instr, 32'h0);
      fetch(32'h0000_2ffc);
      chk("t4_below_err", 32'(f_err), 32'd1);
      fetch(32'h0000_7000);
      chk("t4_above_err", 32'(f_err), 32'd1);
      chk("t4_above_instr", f_instr, 32'h0);
      fetch(32'h0000_6ffc);
      chk("t4_top_err", 32'(f_err), 32'd0);
      chk("t4_top_instr", f_instr, init_word(4095));

      l_req = 1'b1; l_addr = 32'h0000_3200; l_wdata = $urandom; l_last = 1'b0;
      @(posedge clk); #1;
      l_addr = 32'h0000_3204; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; l_req = 1'b0;
      chk("t5_f_valid", 32'(f_valid), 32'd0);
      chk("t5_f_instr", f_instr, 32'h0);
      chk("t5_l_err", 32'(l_err), 32'd0);
      chk("t5_l_done", 32'(l_done), 32'd0);
      chk("t5_mem_en", 32'(mem_en), 32'd0);
      fetch(32'h0000_3000);
      chk("t5_refetch_err", 32'(f_err), 32'd0);

      t0 = $time;
      for (int k = 0; k < 8; k++) fetch(32'h0000_3000 + 32'(k) * 32'd4);
      chk("t6_cycles", 32'(int'(($time - t0) / 10)), 32'd8);

      fork
         repeat (25) begin
            burst(rand_addr(), $urandom_range(12, 1), 2);
            repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
         end
         repeat (150) begin
            repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
            fetch(rand_addr());
         end
      join

      repeat (3) @(posedge clk);
      #1;
      chk("drain_queue", 32'(fq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
